maze_walker: RTL

MAZE_WALKER -- requirements
Module: maze_walker

---
 rtl/maze_walker.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/maze_walker.sv
`default_nettype none
// ============================================================================
// Module   : maze_walker
// Brief    : Wall-following maze walker. It probes neighbouring cells through a
//            registered read/write strobe interface and stops at the maze border.
//            Optional step limit is enabled with `define MAZE_STEP_LIMIT_EN.
// Revision : 1.0
// ============================================================================
module maze_walker #(
    parameter int MAZE_WIDTH = 6,
    parameter int STEP_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MAZE_WIDTH-1:0] starting_row,
    input  logic [MAZE_WIDTH-1:0] starting_col,
    input  logic                  hand_sel,
    input  logic                  maze_in,
    output logic [MAZE_WIDTH-1:0] row,
    output logic [MAZE_WIDTH-1:0] col,
    output logic                  maze_oe,
    output logic                  maze_we,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [STEP_W-1:0]     step_count
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_MARK  = 3'd1;
    localparam logic [2:0] c_S_PROBE = 3'd2;
    localparam logic [2:0] c_S_CHECK = 3'd3;
    localparam logic [2:0] c_S_WRITE = 3'd4;
    localparam logic [2:0] c_S_DONE  = 3'd5;
    localparam logic [2:0] c_S_FAIL  = 3'd6;

    localparam logic [1:0] c_HEAD_N = 2'd0;
    localparam logic [1:0] c_HEAD_E = 2'd1;
    localparam logic [1:0] c_HEAD_S = 2'd2;

    localparam logic [MAZE_WIDTH-1:0] c_ONE      = MAZE_WIDTH'(1);
    localparam logic [MAZE_WIDTH-1:0] c_EDGE     = {MAZE_WIDTH{1'b1}};
    localparam logic [STEP_W-1:0]     c_STEP_ONE = STEP_W'(1);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [MAZE_WIDTH-1:0] r_cur_row;
    logic [MAZE_WIDTH-1:0] r_cur_col;
    logic [1:0]            r_head;
    logic [1:0]            r_cand;
    logic                  r_hand;
    logic [2:0]            r_turns;
    logic [STEP_W-1:0]     r_steps;
    logic [MAZE_WIDTH-1:0] r_row;
    logic [MAZE_WIDTH-1:0] r_col;
    logic                  r_oe;
    logic                  r_we;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_fail;

    logic                  w_cur_border;
    logic                  w_limit_hit;
    logic [1:0]            w_hand_side;
    logic [1:0]            w_cand_rot;
    logic [1:0]            w_cand_nxt;
    logic [2:0]            w_turns_inc;
    logic [STEP_W-1:0]     w_steps_inc;
    logic [2*MAZE_WIDTH-1:0] w_probe_cell;
    logic [MAZE_WIDTH-1:0] w_row_nxt;
    logic [MAZE_WIDTH-1:0] w_col_nxt;
    logic                  w_oe_nxt;
    logic                  w_we_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_fail_nxt;

    function automatic logic [2*MAZE_WIDTH-1:0] step_to(
        input logic [MAZE_WIDTH-1:0] r,
        input logic [MAZE_WIDTH-1:0] c,
        input logic [1:0]            dir
    );
        case (dir)
            c_HEAD_N: step_to = {r - c_ONE, c};
            c_HEAD_E: step_to = {r, c + c_ONE};
            c_HEAD_S: step_to = {r + c_ONE, c};
            default:  step_to = {r, c - c_ONE};
        endcase
    endfunction

    assign w_cur_border = (r_cur_row == '0) || (r_cur_row == c_EDGE) ||
                          (r_cur_col == '0) || (r_cur_col == c_EDGE);

    // Right-hand walker turns clockwise toward its hand, left-hand anticlockwise;
    // a blocked probe rotates the opposite way.
    assign w_hand_side = r_hand ? (r_head - 2'd1) : (r_head + 2'd1);
    assign w_cand_rot  = r_hand ? (r_cand + 2'd1) : (r_cand - 2'd1);
    assign w_cand_nxt  = (r_state == c_S_CHECK) ? w_cand_rot : w_hand_side;
    assign w_turns_inc = r_turns + 3'd1;
    assign w_steps_inc = (&r_steps) ? r_steps : (r_steps + c_STEP_ONE);
    assign w_probe_cell = step_to(r_cur_row, r_cur_col, w_cand_nxt);

`ifdef MAZE_STEP_LIMIT_EN
    assign w_limit_hit = &r_steps;
`else
    assign w_limit_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE, c_S_DONE, c_S_FAIL: begin
                if (start) w_state_nxt = c_S_MARK;
            end
            c_S_MARK:  w_state_nxt = w_cur_border ? c_S_DONE : c_S_PROBE;
            c_S_PROBE: w_state_nxt = c_S_CHECK;
            c_S_CHECK: begin
                if (!maze_in)                  w_state_nxt = c_S_WRITE;
                else if (w_turns_inc == 3'd4)  w_state_nxt = c_S_FAIL;
                else                           w_state_nxt = c_S_PROBE;
            end
            c_S_WRITE: begin
                if (w_cur_border)     w_state_nxt = c_S_DONE;
                else if (w_limit_hit) w_state_nxt = c_S_FAIL;
                else                  w_state_nxt = c_S_PROBE;
            end
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // Outputs are registered, so their next values follow the next state.
    always_comb begin
        w_row_nxt  = r_row;
        w_col_nxt  = r_col;
        w_oe_nxt   = 1'b0;
        w_we_nxt   = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_fail_nxt = 1'b0;
        case (w_state_nxt)
            c_S_MARK: begin
                w_row_nxt  = starting_row;
                w_col_nxt  = starting_col;
                w_we_nxt   = 1'b1;
                w_busy_nxt = 1'b1;
            end
            c_S_PROBE: begin
                {w_row_nxt, w_col_nxt} = w_probe_cell;
                w_oe_nxt   = 1'b1;
                w_busy_nxt = 1'b1;
            end
            c_S_CHECK: w_busy_nxt = 1'b1;
            c_S_WRITE: begin
                w_we_nxt   = 1'b1;
                w_busy_nxt = 1'b1;
            end
            c_S_DONE:  w_done_nxt = 1'b1;
            c_S_FAIL: begin
                w_row_nxt  = r_cur_row;
                w_col_nxt  = r_cur_col;
                w_fail_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row     <= '0;
            r_col     <= '0;
            r_oe      <= 1'b0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
            r_cur_row <= '0;
            r_cur_col <= '0;
            r_head    <= c_HEAD_N;
            r_cand    <= c_HEAD_N;
            r_hand    <= 1'b0;
            r_turns   <= '0;
            r_steps   <= '0;
        end else begin
            r_row  <= w_row_nxt;
            r_col  <= w_col_nxt;
            r_oe   <= w_oe_nxt;
            r_we   <= w_we_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_fail <= w_fail_nxt;
            if (w_state_nxt == c_S_PROBE) r_cand <= w_cand_nxt;
            case (r_state)
                c_S_IDLE, c_S_DONE, c_S_FAIL: begin
                    if (start) begin
                        r_cur_row <= starting_row;
                        r_cur_col <= starting_col;
                        r_hand    <= hand_sel;
                        r_head    <= c_HEAD_N;
                        r_turns   <= '0;
                        r_steps   <= '0;
                    end
                end
                c_S_CHECK: begin
                    if (!maze_in) begin
                        r_cur_row <= r_row;
                        r_cur_col <= r_col;
                        r_head    <= r_cand;
                        r_steps   <= w_steps_inc;
                        r_turns   <= '0;
                    end else begin
                        r_turns   <= w_turns_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign row        = r_row;
    assign col        = r_col;
    assign maze_oe    = r_oe;
    assign maze_we    = r_we;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fail       = r_fail;
    assign step_count = r_steps;

endmodule
`default_nettype wire
